// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the returned word into the IF/ID pipeline register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] IMEM_LAST_ADDR = 32'd84,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misalign_err
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_pc_plus4;
    logic        r_if_id_valid;
    logic        r_halted;
    logic        r_misalign_err;

    logic [31:0] w_pc_plus4;
    logic        w_target_misaligned;

    assign w_pc_plus4          = r_pc + 32'd4;
    assign w_target_misaligned = (redirect_pc[1:0] != 2'b00);

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= RUN;
            r_pc             <= RESET_PC;
            r_if_id_instr    <= NOP_INSTR;
            r_if_id_pc       <= 32'd0;
            r_if_id_pc_plus4 <= 32'd0;
            r_if_id_valid    <= 1'b0;
            r_halted         <= 1'b0;
            r_misalign_err   <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (redirect && w_target_misaligned) begin
                        r_state        <= HALT;
                        r_halted       <= 1'b1;
                        r_misalign_err <= 1'b1;
                        r_if_id_instr  <= NOP_INSTR;
                        r_if_id_valid  <= 1'b0;
                    end else if (redirect) begin
                        // The word fetched this cycle is on the wrong path; drop it.
                        r_pc          <= redirect_pc;
                        r_if_id_instr <= NOP_INSTR;
                        r_if_id_valid <= 1'b0;
                    end else if (stall) begin
                        r_pc <= r_pc;
                    end else if (r_pc > IMEM_LAST_ADDR) begin
                        r_state       <= HALT;
                        r_halted      <= 1'b1;
                        r_if_id_instr <= NOP_INSTR;
                        r_if_id_valid <= 1'b0;
                    end else begin
                        r_if_id_instr    <= instr_in;
                        r_if_id_pc       <= r_pc;
                        r_if_id_pc_plus4 <= w_pc_plus4;
                        r_if_id_valid    <= 1'b1;
                        r_pc             <= w_pc_plus4;
                    end
                end
                HALT: begin
                    r_if_id_instr <= NOP_INSTR;
                    r_if_id_valid <= 1'b0;
                end
                default: r_state <= HALT;
            endcase
        end
    end

    assign pc_out         = r_pc;
    assign if_id_instr    = r_if_id_instr;
    assign if_id_pc       = r_if_id_pc;
    assign if_id_pc_plus4 = r_if_id_pc_plus4;
    assign if_id_valid    = r_if_id_valid;
    assign halted         = r_halted;
    assign misalign_err   = r_misalign_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, redirect, halts.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .instr_in      (instr_in),
        .pc_out        (pc_out),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .misalign_err  (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: each word encodes its own address.
    function automatic logic [31:0] mem(input logic [31:0] addr);
        return {16'hC0DE, addr[15:0]};
    endfunction

    assign instr_in = mem(pc_out);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full-state comparison of every output against hand-derived values.
    task automatic expect_state(input string name, input logic [31:0] e_pc,
                                input logic [31:0] e_instr, input logic [31:0] e_ifpc,
                                input logic [31:0] e_ifpc4, input logic e_valid,
                                input logic e_halt, input logic e_mis);
        checks++;
        if (pc_out !== e_pc) begin
            errors++;
            $display("FAIL %s pc_out got %h want %h", name, pc_out, e_pc);
        end
        checks++;
        if (if_id_instr !== e_instr) begin
            errors++;
            $display("FAIL %s if_id_instr got %h want %h", name, if_id_instr, e_instr);
        end
        checks++;
        if (if_id_pc !== e_ifpc) begin
            errors++;
            $display("FAIL %s if_id_pc got %h want %h", name, if_id_pc, e_ifpc);
        end
        checks++;
        if (if_id_pc_plus4 !== e_ifpc4) begin
            errors++;
            $display("FAIL %s if_id_pc_plus4 got %h want %h", name, if_id_pc_plus4, e_ifpc4);
        end
        checks++;
        if (if_id_valid !== e_valid) begin
            errors++;
            $display("FAIL %s if_id_valid got %b want %b", name, if_id_valid, e_valid);
        end
        checks++;
        if (halted !== e_halt) begin
            errors++;
            $display("FAIL %s halted got %b want %b", name, halted, e_halt);
        end
        checks++;
        if (misalign_err !== e_mis) begin
            errors++;
            $display("FAIL %s misalign_err got %b want %b", name, misalign_err, e_mis);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        step();
        step();
        reset = 1'b0;
        expect_state("reset", 32'd0, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_sequential();
        step();
        expect_state("seq0", 32'd4, 32'hC0DE_0000, 32'd0, 32'd4, 1'b1, 1'b0, 1'b0);
        step();
        expect_state("seq1", 32'd8, 32'hC0DE_0004, 32'd4, 32'd8, 1'b1, 1'b0, 1'b0);
        step();
        expect_state("seq2", 32'd12, 32'hC0DE_0008, 32'd8, 32'd12, 1'b1, 1'b0, 1'b0);
        step();
        expect_state("seq3", 32'd16, 32'hC0DE_000C, 32'd12, 32'd16, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        stall = 1'b1;
        step();
        expect_state("stall1", 32'd16, 32'hC0DE_000C, 32'd12, 32'd16, 1'b1, 1'b0, 1'b0);
        step();
        expect_state("stall2", 32'd16, 32'hC0DE_000C, 32'd12, 32'd16, 1'b1, 1'b0, 1'b0);
        stall = 1'b0;
        step();
        expect_state("stall_resume", 32'd20, 32'hC0DE_0010, 32'd16, 32'd20, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_pc = 32'd56;
        step();
        redirect = 1'b0;
        expect_state("redir_bubble", 32'd56, NOP, 32'd16, 32'd20, 1'b0, 1'b0, 1'b0);
        step();
        expect_state("redir_target", 32'd60, 32'hC0DE_0038, 32'd56, 32'd60, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_redirect_over_stall();
        redirect = 1'b1; redirect_pc = 32'd40; stall = 1'b1;
        step();
        redirect = 1'b0; stall = 1'b0;
        expect_state("redir_stall", 32'd40, NOP, 32'd56, 32'd60, 1'b0, 1'b0, 1'b0);
        step();
        expect_state("redir_stall_next", 32'd44, 32'hC0DE_0028, 32'd40, 32'd44, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_run_off_end();
        // pc 44 .. 84 inclusive is 11 more fetches.
        for (int i = 0; i < 11; i++) step();
        expect_state("last_fetch", 32'd88, 32'hC0DE_0054, 32'd84, 32'd88, 1'b1, 1'b0, 1'b0);
        step();
        expect_state("end_halt", 32'd88, NOP, 32'd84, 32'd88, 1'b0, 1'b1, 1'b0);
        redirect = 1'b1; redirect_pc = 32'd8;
        step();
        redirect = 1'b0;
        expect_state("end_halt_redir", 32'd88, NOP, 32'd84, 32'd88, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_state("reset_from_halt", 32'd0, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        step();
        expect_state("resume_after_reset", 32'd4, 32'hC0DE_0000, 32'd0, 32'd4, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_misalign();
        redirect = 1'b1; redirect_pc = 32'h0000_003A;
        step();
        redirect = 1'b0;
        expect_state("misalign", 32'd4, NOP, 32'd0, 32'd4, 1'b0, 1'b1, 1'b1);
        redirect = 1'b1; redirect_pc = 32'd8; stall = 1'b1;
        step();
        expect_state("misalign_redir_ignored", 32'd4, NOP, 32'd0, 32'd4, 1'b0, 1'b1, 1'b1);
        redirect = 1'b0; stall = 1'b0;
        step();
        step();
        expect_state("misalign_frozen", 32'd4, NOP, 32'd0, 32'd4, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_state("misalign_reset", 32'd0, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_over_stall();
        test_run_off_end();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
